pry2oht_rr_arbiter: RTL and testbench

//   Registered round-robin arbiter built on the rightmost-priority one-hot encoder
//   (pry2oht_tree). It is instantiated twice: once on masked requests, once on raw.
//   It grants one of WIDTH requesters with a valid/ready handshake. After each

---
 rtl/pry2oht_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_pry2oht_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pry2oht_rr_arbiter.sv
// Registered round-robin arbiter over two rightmost-priority one-hot encoders (masked and raw).
// Optional burst lock enabled by defining PRY2OHT_RR_ARBITER_LOCK_EN.

module pry2oht_tree #(
  parameter int WIDTH          = 4,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] oht
);
  localparam int LOG_S  = $clog2(SPLIT);
  localparam int LEVELS = ($clog2(WIDTH) + LOG_S - 1) / LOG_S;

  generate
    if (IMPLEMENTATION == 0) begin : g_tree
      // A bit wins when, at every tree level, no lower sibling group holds a set bit.
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [LEVELS-1:0] blk;
        for (genvar gl = 0; gl < LEVELS; gl++) begin : g_lvl
          localparam int CB = (gi / (SPLIT ** gl)) * (SPLIT ** gl);
          localparam int GB = (gi / (SPLIT ** (gl + 1))) * (SPLIT ** (gl + 1));
          localparam logic [WIDTH-1:0] SIB_MASK =
            ({WIDTH{1'b1}} << GB) & ~({WIDTH{1'b1}} << CB);
          assign blk[gl] = |(vec & SIB_MASK);
        end
        assign oht[gi] = vec[gi] & ~|blk;
      end
    end else begin : g_flat
      assign oht = vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});
    end
  endgenerate
endmodule

module pry2oht_rr_arbiter #(
  parameter int WIDTH          = 4,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0,
  localparam int IDX_W         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic [WIDTH-1:0] gnt_oht,
  output logic [IDX_W-1:0] gnt_idx
`ifdef PRY2OHT_RR_ARBITER_LOCK_EN
  ,
  input  logic             lock
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [WIDTH-1:0]   gnt_oht_q, gnt_oht_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               hs, lock_hit;
  logic [WIDTH-1:0]   masked, oht_m, oht_r, winner;
  logic [IDX_W-1:0]   win_idx;

  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_pry_masked (
    .vec (masked),
    .oht (oht_m)
  );

  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_pry_raw (
    .vec (req),
    .oht (oht_r)
  );

  // Arbitration after a handshake must see the rotated mask so back-to-back grants advance.
  always_comb begin
    hs       = (state_q == GRANT) & gnt_rdy;
`ifdef PRY2OHT_RR_ARBITER_LOCK_EN
    lock_hit = hs & lock & |(req & gnt_oht_q);
`else
    lock_hit = 1'b0;
`endif
    mask_d   = mask_q;
    if (hs && !lock_hit) begin
      mask_d = ~((gnt_oht_q << 1) - {{(WIDTH-1){1'b0}}, 1'b1});
    end
    masked = req & mask_d;
  end

  always_comb begin
    winner  = lock_hit ? gnt_oht_q : ((|masked) ? oht_m : oht_r);
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (winner[i]) win_idx = win_idx | IDX_W'(i);
    end
    state_d   = state_q;
    gnt_oht_d = gnt_oht_q;
    gnt_idx_d = gnt_idx_q;
    if (state_q == IDLE || hs) begin
      if (|winner) begin
        state_d   = GRANT;
        gnt_oht_d = winner;
        gnt_idx_d = win_idx;
      end else begin
        state_d   = IDLE;
        gnt_oht_d = '0;
        gnt_idx_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '1;
      gnt_oht_q <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      gnt_oht_q <= gnt_oht_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_vld = (state_q == GRANT);
  assign gnt_oht = gnt_oht_q;
  assign gnt_idx = gnt_idx_q;
endmodule

// File: tb/tb_pry2oht_rr_arbiter.sv
// Scoreboard bench for pry2oht_rr_arbiter: a 4-wide binary-split instance and a 5-wide SPLIT=4 instance.
// Define PRY2OHT_RR_ARBITER_LOCK_EN to also exercise the burst lock.

module tb_pry2oht_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       gnt_rdy;
  logic       gnt_vld;
  logic [3:0] gnt_oht;
  logic [1:0] gnt_idx;
  logic       lock;
  logic [4:0] req5;
  logic       rdy5;
  logic       vld5;
  logic [4:0] oht5;
  logic [2:0] idx5;
  logic       lock5;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp5_q[$];

  always #5 clk = ~clk;

  pry2oht_rr_arbiter #(.WIDTH(4), .SPLIT(2), .IMPLEMENTATION(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt_vld (gnt_vld),
    .gnt_rdy (gnt_rdy),
    .gnt_oht (gnt_oht),
    .gnt_idx (gnt_idx)
`ifdef PRY2OHT_RR_ARBITER_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  pry2oht_rr_arbiter #(.WIDTH(5), .SPLIT(4), .IMPLEMENTATION(0)) dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req5),
    .gnt_vld (vld5),
    .gnt_rdy (rdy5),
    .gnt_oht (oht5),
    .gnt_idx (idx5)
`ifdef PRY2OHT_RR_ARBITER_LOCK_EN
    ,
    .lock    (lock5)
`endif
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end else begin
      $display("ok   %s value=%0d t=%0t", nm, act, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_vld"}, int'(gnt_vld), 0);
    check({nm, "_oht"}, int'(gnt_oht), 0);
    check({nm, "_idx"}, int'(gnt_idx), 0);
  endtask

  // Monitor: compares the presented grant with the queue head; pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(gnt_oht) || ((gnt_oht != 4'd0) != gnt_vld)) begin
        check("w4_invariant", int'({gnt_vld, gnt_oht}), -1);
      end
      if (gnt_vld) begin
        if (exp_q.size() == 0) begin
          check("w4_unexpected_grant", int'(gnt_idx), -1);
        end else begin
          check(gnt_rdy ? "w4_grant_idx" : "w4_stall_idx", int'(gnt_idx), exp_q[0]);
          check(gnt_rdy ? "w4_grant_oht" : "w4_stall_oht", int'(gnt_oht), 1 << exp_q[0]);
          if (gnt_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(oht5) || ((oht5 != 5'd0) != vld5)) begin
        check("w5_invariant", int'({vld5, oht5}), -1);
      end
      if (vld5) begin
        if (exp5_q.size() == 0) begin
          check("w5_unexpected_grant", int'(idx5), -1);
        end else begin
          check("w5_grant_idx", int'(idx5), exp5_q[0]);
          check("w5_grant_oht", int'(oht5), 1 << exp5_q[0]);
          if (rdy5) void'(exp5_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = '0; gnt_rdy = 1'b0; lock = 1'b0;
    req5 = '0; rdy5 = 1'b0; lock5 = 1'b0;
    tick(); tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Full request set rotates 0,1,2,3 then wraps to 0.
    req = 4'b1111; gnt_rdy = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    repeat (5) tick();
    req = 4'b0000;
    tick();
    check_idle("rotate_end");

    // Accept idx 3, then the zero mask wraps the 1001 pattern to idx 0 before idx 3.
    req = 4'b1000;
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
    tick();
    req = 4'b1001;
    tick(); tick();
    req = 4'b0000;
    tick();
    check_idle("wrap_end");

    // Sticky grant held through a five-cycle stall while its request drops.
    gnt_rdy = 1'b0; req = 4'b0100;
    exp_q.push_back(2);
    tick(); tick();
    req = 4'b0000;
    tick(); tick(); tick();
    gnt_rdy = 1'b1;
    tick();
    check_idle("stall_end");

    // Asynchronous reset in the middle of a grant at idx 2.
    gnt_rdy = 1'b0; req = 4'b0100;
    exp_q.push_back(2);
    tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle("async_reset");
    tick();
    rst_n = 1'b1; req = 4'b1111; gnt_rdy = 1'b1;
    exp_q.push_back(0);
    tick();
    req = 4'b0000;
    tick();
    check_idle("post_reset_end");

`ifdef PRY2OHT_RR_ARBITER_LOCK_EN
    // Three locked handshakes on idx 0 keep the grant there, then rotation resumes.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 4'b0011; gnt_rdy = 1'b1; lock = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    tick(); tick(); tick(); tick();
    lock = 1'b0;
    tick(); tick();
    req = 4'b0000;
    tick();
    check_idle("lock_end");
`endif

    // Five requesters on a padded SPLIT=4 tree: idx 4, then wrap to idx 0.
    rdy5 = 1'b1; req5 = 5'b10000;
    exp5_q.push_back(4); exp5_q.push_back(0);
    tick();
    req5 = 5'b10001;
    tick();
    req5 = 5'b00000;
    tick();
    check("w5_idle_vld", int'(vld5), 0);
    check("w5_idle_oht", int'(oht5), 0);

    tick();
    check("w4_queue_drained", exp_q.size(), 0);
    check("w5_queue_drained", exp5_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
